// File: rtl/stream_gather.sv
// stream_gather: collects a serial stream of WIDTH-bit words into N-lane
// parallel vectors. Partial groups (ended by in_last) are zero-padded so a
// downstream sum across all lanes stays correct. One assembly buffer plus one
// output register; when both are full the input is stalled (HOLD).
module stream_gather #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*WIDTH-1:0]         out_data,
  output logic [$clog2(N+1)-1:0]     out_count
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(N+1);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [N-1:0][WIDTH-1:0]    lane_q, lane_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [N-1:0][WIDTH-1:0]    out_data_q, out_data_d;
  logic [CW-1:0]              out_count_q, out_count_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_free_c;

  // Words are only accepted while filling; HOLD means the buffer is complete.
  assign in_ready  = (state_q == ST_FILL);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

  // Output register can take a new vector this cycle if empty or draining.
  assign out_free_c = !out_valid_q || out_ready;

  // Next-state and datapath: assemble words, hand off completed groups.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q && !out_ready;

    case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          lane_d[idx_q] = in_data;
          if ((idx_q == IW'(N-1)) || in_last) begin
            if (out_free_c) begin
              out_data_d  = lane_d;
              out_count_d = CW'(idx_q) + CW'(1);
              out_valid_d = 1'b1;
              lane_d      = '0;
              idx_d       = '0;
            end else begin
              // Keep the completed group (and its index) until the output frees.
              state_d = ST_HOLD;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      ST_HOLD: begin
        // Output is valid here; a transfer swaps the held group in directly.
        if (out_ready) begin
          out_data_d  = lane_q;
          out_count_d = CW'(idx_q) + CW'(1);
          out_valid_d = 1'b1;
          lane_d      = '0;
          idx_d       = '0;
          state_d     = ST_FILL;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State and data registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      lane_q      <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
